// File: rtl/block_serializer_64x10bit_pkg.sv
// rtl/block_serializer_64x10bit_pkg.sv - shared constants, zigzag table and block unpack helper
// Package jpeg_blk_pkg:
//   BLK_DEPTH / BLK_DW / BLK_BITS : block geometry (64 samples x 10 bits = 640 bits)
//   ZIGZAG                        : JPEG zigzag scan, beat -> raster source index
//   state_t                       : serializer control states
//   unpack_sample()               : extract sample k from a packed block (sample 0 in MSBs)
package jpeg_blk_pkg;

    localparam int BLK_DEPTH = 64;
    localparam int BLK_DW    = 10;
    localparam int BLK_BITS  = BLK_DEPTH * BLK_DW;

    localparam logic [5:0] ZIGZAG [BLK_DEPTH] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    function automatic logic [BLK_DW-1:0] unpack_sample(input logic [BLK_BITS-1:0] blk,
                                                        input logic [5:0]          k);
        return blk[BLK_BITS - 1 - BLK_DW * int'(k) -: BLK_DW];
    endfunction

endpackage

// File: rtl/block_serializer_64x10bit_if.sv
// rtl/block_serializer_64x10bit_if.sv - block input / sample output handshake bundle
// Signals:
//   in_valid, in_ready, in_block_640bits : block input handshake (sample 0 in MSBs)
//   flush                                : synchronous abort of the current block
//   out_valid, out_ready                 : sample output handshake
//   out_data, out_index, out_last        : sample, beat number 0..63, last-beat flag
// Modports: master = producer/consumer side, slave = serializer side.
interface block_serializer_64x10bit_if;
    import jpeg_blk_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [BLK_BITS-1:0] in_block_640bits;
    logic                flush;
    logic                out_valid;
    logic                out_ready;
    logic [BLK_DW-1:0]   out_data;
    logic [5:0]          out_index;
    logic                out_last;

    modport master (
        output in_valid, in_block_640bits, flush, out_ready,
        input  in_ready, out_valid, out_data, out_index, out_last
    );

    modport slave (
        input  in_valid, in_block_640bits, flush, out_ready,
        output in_ready, out_valid, out_data, out_index, out_last
    );

endinterface

// File: rtl/block_serializer_64x10bit_order_rom.sv
// rtl/block_serializer_64x10bit_order_rom.sv - beat number to source sample index
// Module blk_order_rom. Macro ZIGZAG_ORDER_EN selects JPEG zigzag order; otherwise raster.
// Ports:
//   beat : output beat number 0..63
//   src  : index of the stored sample to present on that beat
module blk_order_rom
    import jpeg_blk_pkg::*;
(
    input  logic [5:0] beat,
    output logic [5:0] src
);

`ifdef ZIGZAG_ORDER_EN
    assign src = ZIGZAG[beat];
`else
    assign src = beat;
`endif

endmodule

// File: rtl/block_serializer_64x10bit.sv
// rtl/block_serializer_64x10bit.sv - captures a 64x10-bit block and streams it one sample per beat
// Optional macro ZIGZAG_ORDER_EN: stream in JPEG zigzag order instead of raster order.
// Ports:
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : slave side of block_serializer_64x10bit_if (block in, samples out, flush)
module block_serializer_64x10bit
    import jpeg_blk_pkg::*;
#(
    parameter int DATA_WIDTH = BLK_DW,
    parameter int DEPTH      = BLK_DEPTH
) (
    input  logic                         clock,
    input  logic                         reset_n,
    block_serializer_64x10bit_if.slave   bus
);

    state_t                state;
    logic [5:0]            beat;
    logic [DATA_WIDTH-1:0] storage [DEPTH];
    logic [5:0]            src;
    logic                  last_beat;
    logic                  out_hs;
    logic                  in_hs;

    assign last_beat = (beat == 6'd63);
    assign out_hs    = (state == ST_STREAM) && bus.out_ready;

    // Accepting on the last output beat lets the next block follow with no bubble;
    // flush always blocks acceptance in the cycle it is asserted.
    assign bus.in_ready = !bus.flush && ((state == ST_IDLE) || (out_hs && last_beat));
    assign in_hs        = bus.in_valid && bus.in_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            beat  <= 6'd0;
        end else if (bus.flush) begin
            state <= ST_IDLE;
            beat  <= 6'd0;
        end else if (in_hs) begin
            state <= ST_STREAM;
            beat  <= 6'd0;
        end else if (out_hs) begin
            if (last_beat) begin
                state <= ST_IDLE;
                beat  <= 6'd0;
            end else begin
                beat <= beat + 6'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                storage[k] <= '0;
            end
        end else if (in_hs) begin
            for (int k = 0; k < DEPTH; k++) begin
                storage[k] <= unpack_sample(bus.in_block_640bits, 6'(k));
            end
        end
    end

    blk_order_rom u_order_rom (
        .beat (beat),
        .src  (src)
    );

    assign bus.out_valid = (state == ST_STREAM);
    assign bus.out_data  = storage[src];
    assign bus.out_index = beat;
    assign bus.out_last  = last_beat;

endmodule

// File: tb/tb_block_serializer_64x10bit.sv
// tb/tb_block_serializer_64x10bit.sv - randomized self-checking bench for block_serializer_64x10bit
module tb_block_serializer_64x10bit;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    block_serializer_64x10bit_if bus ();

    block_serializer_64x10bit dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int ord [64];
    logic [63:0][9:0] blk_a;
    logic [63:0][9:0] blk_b;

    // Scan order built from the 8x8 geometry: raster, or anti-diagonal walk for zigzag.
    task automatic build_order();
        int n = 0;
`ifdef ZIGZAG_ORDER_EN
        for (int s = 0; s < 15; s++) begin
            int lo = (s > 7) ? s - 7 : 0;
            int hi = (s < 7) ? s : 7;
            if (s % 2 == 0) begin
                for (int r = hi; r >= lo; r--) begin ord[n] = r * 8 + (s - r); n++; end
            end else begin
                for (int r = lo; r <= hi; r++) begin ord[n] = r * 8 + (s - r); n++; end
            end
        end
`else
        for (int i = 0; i < 64; i++) begin ord[n] = i; n++; end
`endif
    endtask

    function automatic logic [639:0] pack_blk(input logic [63:0][9:0] s);
        logic [639:0] v;
        for (int k = 0; k < 64; k++) v[639 - 10 * k -: 10] = s[k];
        return v;
    endfunction

    function automatic logic [9:0] model(input logic [63:0][9:0] s, input int b);
        return s[ord[b]];
    endfunction

    function automatic logic [18:0] observed();
        return {bus.out_valid, bus.out_data, bus.out_index, bus.out_last, bus.in_ready};
    endfunction

    task automatic test_reset();
        #1;
        total_cnt++;
        if ({bus.out_valid, bus.out_data, bus.out_index, bus.out_last} !== 18'd0)
            $display("FAIL reset_hold: got %h exp 0", {bus.out_valid, bus.out_data, bus.out_index, bus.out_last});
        else pass_cnt++;
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        total_cnt++;
        if (observed() !== 19'd1) $display("FAIL reset_release: got %h exp %h", observed(), 19'd1);
        else pass_cnt++;
    endtask

    task automatic test_raster();
        for (int k = 0; k < 64; k++) blk_a[k] = 10'(k);
        @(negedge clock);
        bus.in_valid = 1'b1; bus.in_block_640bits = pack_blk(blk_a); bus.out_ready = 1'b1;
        #1;
        total_cnt++;
        if (bus.in_ready !== 1'b1) $display("FAIL raster_accept: in_ready got %b exp 1", bus.in_ready);
        else pass_cnt++;
        for (int b = 0; b < 64; b++) begin
            @(negedge clock);
            bus.in_valid = 1'b0;
            #1;
            total_cnt++;
            if (observed() !== {1'b1, model(blk_a, b), 6'(b), b == 63, b == 63})
                $display("FAIL raster beat %0d: got %h exp %h", b, observed(),
                         {1'b1, model(blk_a, b), 6'(b), b == 63, b == 63});
            else pass_cnt++;
        end
        @(negedge clock);
        #1;
        total_cnt++;
        if ({bus.out_valid, bus.in_ready} !== 2'b01)
            $display("FAIL raster_idle: got %b exp 01", {bus.out_valid, bus.in_ready});
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        int eb = 0, stall = 0, cyc = 0, cnt5 = 0;
        for (int k = 0; k < 64; k++) blk_a[k] = 10'($urandom_range(0, 1023));
        @(negedge clock);
        bus.in_valid = 1'b1; bus.in_block_640bits = pack_blk(blk_a); bus.out_ready = 1'b0;
        #1;
        total_cnt++;
        if (bus.in_ready !== 1'b1) $display("FAIL bp_accept: in_ready got %b exp 1", bus.in_ready);
        else pass_cnt++;
        while (eb < 64 && cyc < 1000) begin
            @(negedge clock);
            bus.in_valid = 1'b0;
            if (eb == 5 && stall < 3) begin
                bus.out_ready = 1'b0;
                stall++;
            end else if (eb == 5) begin
                bus.out_ready = 1'b1;
            end else begin
                bus.out_ready = ($urandom_range(0, 3) != 0);
            end
            #1;
            if (bus.out_index == 6'd5) cnt5++;
            total_cnt++;
            if (observed() !== {1'b1, model(blk_a, eb), 6'(eb), eb == 63, eb == 63 && bus.out_ready})
                $display("FAIL bp beat %0d: got %h exp %h", eb, observed(),
                         {1'b1, model(blk_a, eb), 6'(eb), eb == 63, eb == 63 && bus.out_ready});
            else pass_cnt++;
            if (bus.out_ready) eb++;
            cyc++;
        end
        total_cnt++;
        if (eb != 64) $display("FAIL bp_timeout: beats got %0d exp 64", eb);
        else pass_cnt++;
        total_cnt++;
        if (cnt5 != 4) $display("FAIL bp_hold5: cycles got %0d exp 4", cnt5);
        else pass_cnt++;
        @(negedge clock);
        bus.out_ready = 1'b1;
        #1;
        total_cnt++;
        if (bus.out_valid !== 1'b0) $display("FAIL bp_idle: out_valid got %b exp 0", bus.out_valid);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 64; k++) begin
            blk_a[k] = 10'(k);
            blk_b[k] = 10'(100 + k);
        end
        @(negedge clock);
        bus.in_valid = 1'b1; bus.in_block_640bits = pack_blk(blk_a); bus.out_ready = 1'b1;
        #1;
        total_cnt++;
        if (bus.in_ready !== 1'b1) $display("FAIL b2b_accept: in_ready got %b exp 1", bus.in_ready);
        else pass_cnt++;
        for (int b = 0; b < 64; b++) begin
            @(negedge clock);
            bus.in_valid = 1'b1; bus.in_block_640bits = pack_blk(blk_b);
            #1;
            total_cnt++;
            if (observed() !== {1'b1, model(blk_a, b), 6'(b), b == 63, b == 63})
                $display("FAIL b2b_a beat %0d: got %h exp %h", b, observed(),
                         {1'b1, model(blk_a, b), 6'(b), b == 63, b == 63});
            else pass_cnt++;
        end
        for (int b = 0; b < 64; b++) begin
            @(negedge clock);
            bus.in_valid = 1'b0;
            #1;
            total_cnt++;
            if (observed() !== {1'b1, model(blk_b, b), 6'(b), b == 63, b == 63})
                $display("FAIL b2b_b beat %0d: got %h exp %h", b, observed(),
                         {1'b1, model(blk_b, b), 6'(b), b == 63, b == 63});
            else pass_cnt++;
        end
        @(negedge clock);
        #1;
        total_cnt++;
        if (bus.out_valid !== 1'b0) $display("FAIL b2b_idle: out_valid got %b exp 0", bus.out_valid);
        else pass_cnt++;
    endtask

    task automatic test_flush();
        for (int k = 0; k < 64; k++) begin
            blk_a[k] = 10'($urandom_range(0, 1023));
            blk_b[k] = 10'($urandom_range(0, 1023));
        end
        // flush while idle only suppresses acceptance that cycle
        @(negedge clock);
        bus.flush = 1'b1; bus.in_valid = 1'b1; bus.in_block_640bits = pack_blk(blk_b);
        #1;
        total_cnt++;
        if (bus.in_ready !== 1'b0) $display("FAIL flush_idle_ready: got %b exp 0", bus.in_ready);
        else pass_cnt++;
        @(negedge clock);
        bus.flush = 1'b0; bus.in_valid = 1'b1; bus.in_block_640bits = pack_blk(blk_a);
        #1;
        total_cnt++;
        if ({bus.out_valid, bus.in_ready} !== 2'b01)
            $display("FAIL flush_idle_after: got %b exp 01", {bus.out_valid, bus.in_ready});
        else pass_cnt++;
        for (int b = 0; b <= 10; b++) begin
            @(negedge clock);
            if (b == 10) begin
                bus.flush = 1'b1; bus.in_valid = 1'b1; bus.in_block_640bits = pack_blk(blk_b);
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            total_cnt++;
            if (observed() !== {1'b1, model(blk_a, b), 6'(b), 1'b0, 1'b0})
                $display("FAIL flush_pre beat %0d: got %h exp %h", b, observed(),
                         {1'b1, model(blk_a, b), 6'(b), 1'b0, 1'b0});
            else pass_cnt++;
        end
        @(negedge clock);
        bus.flush = 1'b0; bus.in_valid = 1'b0;
        #1;
        total_cnt++;
        if ({bus.out_valid, bus.out_index, bus.in_ready} !== {1'b0, 6'd0, 1'b1})
            $display("FAIL flush_after: got %h exp %h", {bus.out_valid, bus.out_index, bus.in_ready},
                     {1'b0, 6'd0, 1'b1});
        else pass_cnt++;
        @(negedge clock);
        bus.in_valid = 1'b1; bus.in_block_640bits = pack_blk(blk_b);
        for (int b = 0; b < 64; b++) begin
            @(negedge clock);
            bus.in_valid = 1'b0;
            #1;
            total_cnt++;
            if (observed() !== {1'b1, model(blk_b, b), 6'(b), b == 63, b == 63})
                $display("FAIL flush_c beat %0d: got %h exp %h", b, observed(),
                         {1'b1, model(blk_b, b), 6'(b), b == 63, b == 63});
            else pass_cnt++;
        end
        @(negedge clock);
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 64; k++) begin
            blk_a[k] = 10'($urandom_range(1, 1023));
            blk_b[k] = 10'($urandom_range(0, 1023));
        end
        @(negedge clock);
        bus.in_valid = 1'b1; bus.in_block_640bits = pack_blk(blk_a); bus.out_ready = 1'b1;
        for (int b = 0; b <= 20; b++) begin
            @(negedge clock);
            bus.in_valid = 1'b0;
            #1;
            total_cnt++;
            if (observed() !== {1'b1, model(blk_a, b), 6'(b), 1'b0, 1'b0})
                $display("FAIL rst_pre beat %0d: got %h exp %h", b, observed(),
                         {1'b1, model(blk_a, b), 6'(b), 1'b0, 1'b0});
            else pass_cnt++;
        end
        #1;
        reset_n = 1'b0;
        #1;
        total_cnt++;
        if ({bus.out_valid, bus.out_data, bus.out_index, bus.out_last} !== 18'd0)
            $display("FAIL rst_async: got %h exp 0", {bus.out_valid, bus.out_data, bus.out_index, bus.out_last});
        else pass_cnt++;
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        total_cnt++;
        if ({bus.out_valid, bus.in_ready} !== 2'b01)
            $display("FAIL rst_release: got %b exp 01", {bus.out_valid, bus.in_ready});
        else pass_cnt++;
        @(negedge clock);
        bus.in_valid = 1'b1; bus.in_block_640bits = pack_blk(blk_b);
        for (int b = 0; b < 64; b++) begin
            @(negedge clock);
            bus.in_valid = 1'b0;
            #1;
            total_cnt++;
            if (observed() !== {1'b1, model(blk_b, b), 6'(b), b == 63, b == 63})
                $display("FAIL rst_next beat %0d: got %h exp %h", b, observed(),
                         {1'b1, model(blk_b, b), 6'(b), b == 63, b == 63});
            else pass_cnt++;
        end
        @(negedge clock);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_block_640bits = '0;
        bus.flush = 1'b0;
        bus.out_ready = 1'b0;
        build_order();
        test_reset();
        test_raster();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, passed %0d of %0d", pass_cnt, total_cnt);
        $fatal(1, "watchdog");
    end

endmodule
